// File: rtl/switch_core_param.sv
// switch_core_param: NPORTS x NPORTS address-routed switch, priority + round-robin egress arbitration, show-ahead egress FIFOs; define SWITCH_DROP_CNT_EN to add per-ingress drop counters
module switch_core_param #(
  parameter int NPORTS = 4,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int DEPTH  = 8,
  parameter int AE_LVL = 2,
  parameter int AF_LVL = 6,
  parameter int PRIO_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NPORTS*AW-1:0]       addr_in,
  input  logic [NPORTS*DW-1:0]       data_in,
  input  logic [NPORTS-1:0]          wr_en,
  output logic [NPORTS-1:0]          data_rcv,
  output logic [NPORTS*AW-1:0]       addr_out,
  output logic [NPORTS*DW-1:0]       data_out,
  input  logic [NPORTS-1:0]          rd_en,
  output logic [NPORTS-1:0]          data_rdy,
  output logic [NPORTS-1:0]          fifo_empty,
  output logic [NPORTS-1:0]          fifo_full,
  output logic [NPORTS-1:0]          fifo_ae,
  output logic [NPORTS-1:0]          fifo_af,
  input  logic                       prio_wr,
  input  logic [NPORTS*PRIO_W-1:0]   prio_val,
  input  logic                       port_en,
  input  logic                       port_wr,
  input  logic [$clog2(NPORTS)-1:0]  port_sel,
  input  logic [AW-1:0]              port_addr
`ifdef SWITCH_DROP_CNT_EN
  ,
  output logic [NPORTS*8-1:0]        drop_cnt
`endif
);
  localparam int PW = $clog2(NPORTS);
  localparam int FW = $clog2(DEPTH);
  localparam int CW = FW + 1;
  localparam int EW = AW + DW;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LVL);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LVL);
  logic [AW-1:0]          tbl_q [NPORTS];
  logic [NPORTS*PRIO_W-1:0] prio_q;
  logic [PW-1:0]          rr_q [NPORTS];
  logic [EW-1:0]          mem_q [NPORTS][DEPTH];
  logic [FW-1:0]          wp_q [NPORTS];
  logic [FW-1:0]          rp_q [NPORTS];
  logic [CW-1:0]          cnt_q [NPORTS];
  logic [NPORTS-1:0]      rcv_q, rcv_d;
  logic [NPORTS-1:0]      hit, push, pop;
  logic [PW-1:0]          dest [NPORTS];
  logic [PW-1:0]          win [NPORTS];
  assign data_rcv = rcv_q;
  assign pop = rd_en & data_rdy;
  // decode each ingress address to the lowest matching egress table entry
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      hit[i] = 1'b0;
      dest[i] = '0;
      for (int j = NPORTS - 1; j >= 0; j--)
        if (tbl_q[j] == addr_in[i*AW +: AW]) begin
          hit[i] = 1'b1;
          dest[i] = PW'(j);
        end
    end
  end
  // per-egress winner: highest priority, ties resolved by scanning from rr_q; unmatched words are consumed
  always_comb begin : arb_p
    logic [NPORTS-1:0] cand;
    logic [PRIO_W-1:0] top;
    logic [PW-1:0]     sel;
    int                idx;
    cand = '0;
    top = '0;
    sel = '0;
    idx = 0;
    rcv_d = wr_en & ~hit;
    for (int j = 0; j < NPORTS; j++) begin
      push[j] = 1'b0;
      win[j] = '0;
      top = '0;
      for (int i = 0; i < NPORTS; i++) begin
        cand[i] = wr_en[i] && hit[i] && dest[i] == PW'(j) && cnt_q[j] != FULL_C;
        if (cand[i] && prio_q[i*PRIO_W +: PRIO_W] > top) top = prio_q[i*PRIO_W +: PRIO_W];
      end
      for (int k = NPORTS - 1; k >= 0; k--) begin
        idx = int'(rr_q[j]) + k;
        idx = idx >= NPORTS ? idx - NPORTS : idx;
        sel = PW'(idx);
        if (cand[sel] && prio_q[sel*PRIO_W +: PRIO_W] == top) begin
          push[j] = 1'b1;
          win[j] = sel;
        end
      end
      if (push[j]) rcv_d[win[j]] = 1'b1;
    end
  end
  // configuration registers and the registered accept pulse
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int j = 0; j < NPORTS; j++) tbl_q[j] <= AW'(j);
      prio_q <= '0;
      rcv_q <= '0;
    end else begin
      if (port_en && port_wr) tbl_q[port_sel] <= port_addr;
      if (prio_wr) prio_q <= prio_val;
      rcv_q <= rcv_d;
    end
  // egress FIFO pointers, occupancy and round-robin pointers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int j = 0; j < NPORTS; j++) begin
        wp_q[j] <= '0;
        rp_q[j] <= '0;
        cnt_q[j] <= '0;
        rr_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NPORTS; j++) begin
        if (push[j]) begin
          wp_q[j] <= wp_q[j] + FW'(1);
          rr_q[j] <= win[j] == PW'(NPORTS - 1) ? '0 : win[j] + PW'(1);
        end
        if (pop[j]) rp_q[j] <= rp_q[j] + FW'(1);
        cnt_q[j] <= cnt_q[j] + CW'(push[j]) - CW'(pop[j]);
      end
    end
  // FIFO storage carries no reset; empty entries are masked at the outputs
  always_ff @(posedge clk)
    for (int j = 0; j < NPORTS; j++)
      if (push[j]) mem_q[j][wp_q[j]] <= {addr_in[win[j]*AW +: AW], data_in[win[j]*DW +: DW]};
  // show-ahead head and status flags from the registered count
  always_comb begin
    for (int j = 0; j < NPORTS; j++) begin
      data_rdy[j] = cnt_q[j] != '0;
      fifo_empty[j] = cnt_q[j] == '0;
      fifo_full[j] = cnt_q[j] == FULL_C;
      fifo_ae[j] = cnt_q[j] <= AE_C;
      fifo_af[j] = cnt_q[j] >= AF_C;
      {addr_out[j*AW +: AW], data_out[j*DW +: DW]} = data_rdy[j] ? mem_q[j][rp_q[j]] : '0;
    end
  end
`ifdef SWITCH_DROP_CNT_EN
  logic [7:0] drop_q [NPORTS];
  // saturating unmatched-address counters, cleared by a config read-access to the port
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NPORTS; i++) drop_q[i] <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++)
        if (port_en && !port_wr && port_sel == PW'(i)) drop_q[i] <= '0;
        else if (wr_en[i] && !hit[i] && drop_q[i] != 8'hFF) drop_q[i] <= drop_q[i] + 8'd1;
    end
  // flatten the counters onto the output bus
  always_comb
    for (int i = 0; i < NPORTS; i++) drop_cnt[i*8 +: 8] = drop_q[i];
`endif
endmodule

// File: tb/tb_switch_core_param.sv
// tb_switch_core_param: directed stimulus with a queue-level reference model checked every cycle
module tb_switch_core_param;
  localparam int N = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int D = 8;
  localparam int PRW = 2;
  logic clk, reset;
  logic [N*AW-1:0] addr_in, addr_out;
  logic [N*DW-1:0] data_in, data_out;
  logic [N-1:0] wr_en, data_rcv, rd_en, data_rdy, fifo_empty, fifo_full, fifo_ae, fifo_af;
  logic prio_wr, port_en, port_wr;
  logic [N*PRW-1:0] prio_val;
  logic [1:0] port_sel;
  logic [AW-1:0] port_addr;
`ifdef SWITCH_DROP_CNT_EN
  logic [N*8-1:0] drop_cnt;
`endif
  int checks = 0;
  int failures = 0;
  int acc_order[$];
  logic [AW-1:0] mt [N];
  int mp [N];
  int mr [N];
  int md [N];
  logic [31:0] mm [N][D];
  int mh [N];
  int ms [N];
  logic [N-1:0] exp_rcv;

  switch_core_param dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in), .wr_en(wr_en),
    .data_rcv(data_rcv), .addr_out(addr_out), .data_out(data_out), .rd_en(rd_en),
    .data_rdy(data_rdy), .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_ae(fifo_ae),
    .fifo_af(fifo_af), .prio_wr(prio_wr), .prio_val(prio_val), .port_en(port_en),
    .port_wr(port_wr), .port_sel(port_sel), .port_addr(port_addr)
`ifdef SWITCH_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: per-egress circular lists, routing and arbitration from the rules
  always @(posedge clk or negedge reset) begin : model
    int sz [N];
    int dst [N];
    int best, w, idx;
    logic [N-1:0] r;
    if (!reset) begin
      for (int j = 0; j < N; j++) begin
        mt[j] = AW'(j); mp[j] = 0; mr[j] = 0; md[j] = 0; mh[j] = 0; ms[j] = 0;
      end
      exp_rcv = '0;
    end else begin
      r = '0;
      for (int j = 0; j < N; j++) sz[j] = ms[j];
      for (int i = 0; i < N; i++) begin
        dst[i] = -1;
        for (int j = N - 1; j >= 0; j--) if (mt[j] == addr_in[i*AW +: AW]) dst[i] = j;
        if (wr_en[i] && dst[i] < 0) begin
          r[i] = 1'b1;
          if (md[i] < 255) md[i]++;
        end
      end
      for (int j = 0; j < N; j++)
        if (rd_en[j] && sz[j] > 0) begin
          mh[j] = (mh[j] + 1) % D;
          ms[j]--;
        end
      for (int j = 0; j < N; j++)
        if (sz[j] < D) begin
          best = -1; w = -1;
          for (int k = 0; k < N; k++) begin
            idx = (mr[j] + k) % N;
            if (wr_en[idx] && dst[idx] == j && mp[idx] > best) begin
              best = mp[idx]; w = idx;
            end
          end
          if (w >= 0) begin
            mm[j][(mh[j] + ms[j]) % D] = {addr_in[w*AW +: AW], data_in[w*DW +: DW]};
            ms[j]++;
            r[w] = 1'b1;
            mr[j] = (w + 1) % N;
          end
        end
      if (port_en && port_wr) mt[port_sel] = port_addr;
      if (port_en && !port_wr) md[port_sel] = 0;
      if (prio_wr) for (int i = 0; i < N; i++) mp[i] = int'(prio_val[i*PRW +: PRW]);
      exp_rcv = r;
    end
  end

  // compare every DUT output with the model each cycle
  always @(negedge clk) begin : cmp
    logic [N-1:0] e_rdy, e_emp, e_full, e_ae, e_af;
    logic [N*AW-1:0] e_ao;
    logic [N*DW-1:0] e_do;
    for (int j = 0; j < N; j++) begin
      e_rdy[j] = ms[j] > 0;
      e_emp[j] = ms[j] == 0;
      e_full[j] = ms[j] == D;
      e_ae[j] = ms[j] <= 2;
      e_af[j] = ms[j] >= 6;
      e_ao[j*AW +: AW] = ms[j] > 0 ? mm[j][mh[j]][31:16] : '0;
      e_do[j*DW +: DW] = ms[j] > 0 ? mm[j][mh[j]][15:0] : '0;
    end
    chk("cmp_data_rcv", 64'(data_rcv), 64'(exp_rcv));
    chk("cmp_data_rdy", 64'(data_rdy), 64'(e_rdy));
    chk("cmp_empty", 64'(fifo_empty), 64'(e_emp));
    chk("cmp_full", 64'(fifo_full), 64'(e_full));
    chk("cmp_ae_af", 64'({fifo_ae, fifo_af}), 64'({e_ae, e_af}));
    chk("cmp_addr_out", 64'(addr_out), 64'(e_ao));
    chk("cmp_data_out", 64'(data_out), 64'(e_do));
`ifdef SWITCH_DROP_CNT_EN
    for (int i = 0; i < N; i++) chk("cmp_drop_cnt", 64'(drop_cnt[i*8 +: 8]), 64'(md[i]));
`endif
  end

  task automatic set_in(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr_in[i*AW +: AW] = a;
    data_in[i*DW +: DW] = d;
  endtask

  // hold the requests in m until each sees data_rcv, bounded
  task automatic send(input logic [N-1:0] m);
    int n;
    n = 0;
    wr_en = m;
    do begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (wr_en[i] && data_rcv[i]) begin
          acc_order.push_back(i);
          wr_en[i] = 1'b0;
        end
      n++;
    end while (wr_en != '0 && n < 40);
    if (wr_en != '0) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=%b required=0", wr_en);
      wr_en = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = '0; rd_en = '0; addr_in = '0; data_in = '0;
    prio_wr = 1'b0; prio_val = '0; port_en = 1'b0; port_wr = 1'b0; port_sel = '0; port_addr = '0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_empty", 64'(fifo_empty), 64'(4'hF));
    chk("rst_ae", 64'(fifo_ae), 64'(4'hF));
    chk("rst_rdy", 64'(data_rdy), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    set_in(2, 16'h0002, 16'hA5A5);
    send(4'b0100);
    chk("t1_rdy", 64'(data_rdy[2]), 64'(1));
    chk("t1_data", 64'(data_out[47:32]), 64'(16'hA5A5));
    chk("t1_addr", 64'(addr_out[47:32]), 64'(16'h0002));
    port_en = 1'b1; port_wr = 1'b1; port_sel = 2'd1; port_addr = 16'h0040;
    @(negedge clk);
    port_en = 1'b0; port_wr = 1'b0;
    set_in(0, 16'h0040, 16'h1234);
    send(4'b0001);
    chk("t2_addr", 64'(addr_out[31:16]), 64'(16'h0040));
    chk("t2_data", 64'(data_out[31:16]), 64'(16'h1234));
    set_in(0, 16'h0001, 16'hDEAD);
    send(4'b0001);
    chk("t2_drop_keep", 64'(data_out[31:16]), 64'(16'h1234));
`ifdef SWITCH_DROP_CNT_EN
    chk("t2_drop_cnt", 64'(drop_cnt[7:0]), 64'(1));
`endif
    prio_wr = 1'b1; prio_val = 8'b00_00_11_00;
    @(negedge clk);
    prio_wr = 1'b0;
    for (int i = 0; i < N; i++) set_in(i, 16'h0003, 16'(16'h0100 + i));
    acc_order.delete();
    send(4'hF);
    chk("t3_count", 64'(acc_order.size()), 64'(4));
    chk("t3_ord0", 64'(acc_order[0]), 64'(1));
    chk("t3_ord1", 64'(acc_order[1]), 64'(2));
    chk("t3_ord2", 64'(acc_order[2]), 64'(3));
    chk("t3_ord3", 64'(acc_order[3]), 64'(0));
    chk("t3_head", 64'(data_out[63:48]), 64'(16'h0101));
    rd_en[3] = 1'b1;
    @(negedge clk);
    rd_en[3] = 1'b0;
    rd_en[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t5_head", 64'(data_out[63:48]), 64'(k == 0 ? 16'h0102 : k == 1 ? 16'h0103 : 16'h0100));
      @(negedge clk);
    end
    chk("t5_rdy", 64'(data_rdy[3]), 64'(0));
    chk("t5_empty", 64'(fifo_empty[3]), 64'(1));
    chk("t5_data0", 64'(data_out[63:48]), 64'(0));
    @(negedge clk);
    chk("t5_underflow", 64'(fifo_empty[3]), 64'(1));
    rd_en[3] = 1'b0;
    port_en = 1'b1; port_wr = 1'b1; port_sel = 2'd3; port_addr = 16'h0077;
    set_in(0, 16'h0003, 16'hBEEF);
    wr_en[0] = 1'b1;
    @(negedge clk);
    port_en = 1'b0; port_wr = 1'b0;
    chk("cfg_same_rcv", 64'(data_rcv[0]), 64'(1));
    wr_en[0] = 1'b0;
    chk("cfg_same_addr", 64'(addr_out[63:48]), 64'(16'h0003));
    chk("cfg_same_data", 64'(data_out[63:48]), 64'(16'hBEEF));
    for (int n = 1; n <= 8; n++) begin
      set_in(0, 16'h0000, 16'(16'h0200 + n));
      send(4'b0001);
      if (n == 2) chk("t4_ae2", 64'(fifo_ae[0]), 64'(1));
      if (n == 3) chk("t4_ae3", 64'(fifo_ae[0]), 64'(0));
      if (n == 5) chk("t4_af5", 64'(fifo_af[0]), 64'(0));
      if (n == 6) chk("t4_af6", 64'({fifo_af[0], fifo_full[0]}), 64'(2'b10));
      if (n == 8) chk("t4_full8", 64'(fifo_full[0]), 64'(1));
    end
    set_in(0, 16'h0000, 16'h0209);
    wr_en[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold", 64'(data_rcv[0]), 64'(0));
    end
    rd_en[0] = 1'b1;
    @(negedge clk);
    rd_en[0] = 1'b0;
    chk("t4_pop_rcv", 64'({data_rcv[0], fifo_full[0]}), 64'(2'b00));
    @(negedge clk);
    chk("t4_9th_rcv", 64'({data_rcv[0], fifo_full[0]}), 64'(2'b11));
    chk("t4_head", 64'(data_out[15:0]), 64'(16'h0202));
    wr_en[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_in(2, 16'h0002, 16'(16'h0300 + k));
      send(4'b0100);
    end
    chk("t6_pre", 64'({fifo_ae[2], fifo_af[2], data_rdy[2]}), 64'(3'b001));
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_empty", 64'(fifo_empty), 64'(4'hF));
    chk("t6_rdy", 64'(data_rdy), 64'(0));
    chk("t6_full_af", 64'({fifo_full, fifo_af}), 64'(0));
    chk("t6_ae", 64'(fifo_ae), 64'(4'hF));
    chk("t6_out", 64'(data_out), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    set_in(0, 16'h0001, 16'h0055);
    send(4'b0001);
    chk("t6_ident_rdy", 64'(data_rdy[1]), 64'(1));
    chk("t6_ident_addr", 64'(addr_out[31:16]), 64'(16'h0001));
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
